// File: rtl/mem_arbiter.sv
// Purpose : shares one program/data memory port between the CPU and a HOST loader/debug port.
// Latency : grant and memory drive are combinational; read data returns one cycle after the grant.
// Backpr. : a requester not granted holds req/we/adr/wdata until gnt; dropping req withdraws it.
//
// Ports:
//   ph1, reset                    clock and asynchronous active-high reset
//   cpu_*  / host_*               request side (req/we/adr/wdata in, gnt/rvalid/rdata out)
//   mem_we/mem_adr/mem_wdata      drive to the memory macro; mem_rdata returns one cycle later
//   last_host                     arbitration pointer, 1 when HOST held the most recent grant
module mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 15,
    parameter int MAX_BURST = 4
) (
    input  logic              ph1,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_adr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              last_host
);

    localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

    logic [3:0] burst_cnt;   // consecutive HOST grants, saturating at 15
    logic       tag_vld;     // a read was granted last cycle
    logic       tag_host;    // owner of that read: 1 = HOST
    logic       cap_hit;
    logic       host_win;
    logic       any_gnt;
    logic       gnt_we;

    // The cap only bites when HOST owns the pointer; the pointer alone would also
    // hand CPU the grant there, but the cap is kept explicit so the burst bound
    // survives any later change to the pointer policy.
    assign cap_hit  = last_host && (burst_cnt >= BURST_CAP) && cpu_req;

    // HOST wins when alone, or when both request and CPU held the last grant.
    assign host_win = host_req && !(cpu_req && (last_host || cap_hit));

    assign host_gnt = host_win && !reset;
    assign cpu_gnt  = cpu_req && !host_win && !reset;
    assign any_gnt  = host_gnt || cpu_gnt;

    // Idle and CPU-granted cycles both present the CPU bus to the memory.
    assign mem_adr   = host_gnt ? host_adr   : cpu_adr;
    assign mem_wdata = host_gnt ? host_wdata : cpu_wdata;
    assign gnt_we    = host_gnt ? host_we    : cpu_we;
    assign mem_we    = any_gnt && gnt_we;

    // Read return: the tag steers the single memory read port to its owner.
    assign cpu_rvalid  = tag_vld && !tag_host && !reset;
    assign host_rvalid = tag_vld &&  tag_host && !reset;
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            last_host <= 1'b0;
            burst_cnt <= 4'd0;
            tag_vld   <= 1'b0;
            tag_host  <= 1'b0;
        end else begin
            // The tag is rewritten every cycle so a stale read never returns twice.
            tag_vld  <= any_gnt && !gnt_we;
            tag_host <= host_gnt;
            if (any_gnt) begin
                last_host <= host_gnt;
                if (host_gnt) begin
                    if (last_host)
                        burst_cnt <= (burst_cnt == 4'd15) ? 4'd15 : burst_cnt + 4'd1;
                    else
                        burst_cnt <= 4'd1;
                end else begin
                    burst_cnt <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [7:0]  cpu_adr, host_adr;
    logic [14:0] cpu_wdata, host_wdata;
    logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
    logic [14:0] cpu_rdata, host_rdata;
    logic        mem_we, last_host;
    logic [7:0]  mem_adr;
    logic [14:0] mem_wdata;
    logic [14:0] mem_rdata;

    logic [14:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(15), .MAX_BURST(4)) dut (
        .ph1(ph1), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .last_host(last_host)
    );

    always #5 ph1 = ~ph1;

    // Synchronous memory macro: write on the edge, read data one cycle after the address.
    always @(posedge ph1) begin
        if (mem_we) mem[mem_adr] <= mem_wdata;
        mem_rdata <= mem[mem_adr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs checked a few ns later, well away from the edge.
    task automatic cyc();
        @(posedge ph1);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 15'h0;
        mem[8'h10] = 15'h1234;
        mem_rdata  = 15'h0;
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_adr = 8'h00; cpu_wdata = 15'h0;
        host_req = 0; host_we = 0; host_adr = 8'h00; host_wdata = 15'h0;

        // Reset: requests present but nothing may be granted.
        #2;
        cpu_req = 1; host_req = 1; host_we = 1;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_last_host", last_host, 0);
        chk("rst_rvalid", {cpu_rvalid, host_rvalid}, 0);
        cyc(); cyc();

        // CPU only read of 8'h10.
        reset = 0;
        host_req = 0; host_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_adr = 8'h10;
        #3;
        chk("cpu_only_gnt", cpu_gnt, 1);
        chk("cpu_only_host_gnt", host_gnt, 0);
        chk("cpu_only_mem_adr", mem_adr, 8'h10);
        cyc();
        cpu_req = 0;
        #3;
        chk("cpu_only_rvalid", cpu_rvalid, 1);
        chk("cpu_only_rdata", cpu_rdata, 15'h1234);
        chk("cpu_only_host_rvalid", host_rvalid, 0);
        chk("cpu_only_host_rdata", host_rdata, 0);

        // Reset asserted while a read tag is valid.
        cyc();
        cpu_req = 1; cpu_adr = 8'h10;
        cyc();
        cpu_req = 0;
        reset = 1;
        #1;
        chk("midrd_rst_cpu_rvalid", cpu_rvalid, 0);
        cyc();
        reset = 0;
        #3;
        chk("midrd_post_cpu_rvalid", cpu_rvalid, 0);
        chk("midrd_post_host_rvalid", host_rvalid, 0);
        chk("midrd_post_last_host", last_host, 0);

        // HOST writes 7ABC to 8'h20, then CPU reads it back.
        cyc();
        host_req = 1; host_we = 1; host_adr = 8'h20; host_wdata = 15'h7ABC;
        #3;
        chk("hw_host_gnt", host_gnt, 1);
        chk("hw_mem_we", mem_we, 1);
        chk("hw_mem_adr", mem_adr, 8'h20);
        chk("hw_mem_wdata", mem_wdata, 15'h7ABC);
        cyc();
        host_req = 0; host_we = 0;
        cpu_req = 1; cpu_we = 0; cpu_adr = 8'h20;
        #3;
        chk("hw_cpu_gnt", cpu_gnt, 1);
        chk("hw_cpu_mem_we", mem_we, 0);
        chk("hw_no_host_rvalid", host_rvalid, 0);
        cyc();
        cpu_req = 0;
        #3;
        chk("hw_cpu_rvalid", cpu_rvalid, 1);
        chk("hw_cpu_rdata", cpu_rdata, 15'h7ABC);

        // Contention from reset: alternating HOST, CPU, HOST, CPU reads.
        cyc();
        reset = 1;
        cyc();
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_adr = 8'h10;
        host_req = 1; host_we = 0; host_adr = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("alt_host_gnt", host_gnt, (i % 2 == 0) ? 1 : 0);
            chk("alt_cpu_gnt", cpu_gnt, (i % 2 == 0) ? 0 : 1);
            if (i > 0) begin
                chk("alt_host_rvalid", host_rvalid, (i % 2 == 1) ? 1 : 0);
                chk("alt_cpu_rvalid", cpu_rvalid, (i % 2 == 0) ? 1 : 0);
                chk("alt_rdata", {cpu_rdata, host_rdata},
                    (i % 2 == 1) ? {15'h0, 15'h7ABC} : {15'h1234, 15'h0});
            end
            cyc();
        end

        // Burst: HOST alone for 3 cycles, then CPU joins and wins on the pointer.
        cpu_req = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("b3_host_gnt", host_gnt, 1);
            cyc();
        end
        cpu_req = 1;
        #3;
        chk("b3_last_host", last_host, 1);
        chk("b3_host_rdata", host_rdata, 15'h7ABC);
        chk("b3_cpu_gnt", cpu_gnt, 1);
        chk("b3_host_gnt", host_gnt, 0);

        // Burst of 4 HOST grants (count reaches MAX_BURST), then CPU wins.
        cyc();
        cpu_req = 0;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("b4_host_gnt", host_gnt, 1);
            cyc();
        end
        cpu_req = 1;
        #3;
        chk("b4_cpu_gnt", cpu_gnt, 1);
        chk("b4_host_gnt", host_gnt, 0);
        cyc();
        #3;
        chk("b4_after_host_gnt", host_gnt, 1);
        chk("b4_after_cpu_gnt", cpu_gnt, 0);

        // Withdrawn HOST request while CPU is granted, then idle.
        cyc();
        cpu_req = 1; cpu_adr = 8'h10;
        host_req = 1;
        #3;
        chk("wd_cpu_gnt", cpu_gnt, 1);
        chk("wd_host_gnt", host_gnt, 0);
        cyc();
        cpu_req = 0; host_req = 0; cpu_adr = 8'h33;
        #3;
        chk("wd_host_rvalid", host_rvalid, 0);
        chk("wd_cpu_rvalid", cpu_rvalid, 1);
        chk("idle_gnts", {cpu_gnt, host_gnt}, 0);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_adr", mem_adr, 8'h33);
        cyc();
        #3;
        chk("idle_last_host", last_host, 0);
        chk("idle_rvalid", {cpu_rvalid, host_rvalid}, 0);
        cyc();
        #3;
        chk("idle_last_host_hold", last_host, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
